// File: rtl/lsu_memory_interface.sv
// Memory-side back end of the load/store unit: one outstanding data-memory request,
// store lane steering, load alignment/extension, kill handling and CDB broadcast.
module lsu_memory_interface #(
    parameter int unsigned XLEN          = 32,
    parameter int unsigned ROB_TAG_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     fire_memory_op,
    input  logic                     memory_op_type,
    input  logic [2:0]               memory_op_width,
    input  logic [XLEN-1:0]          memory_address,
    input  logic [XLEN-1:0]          memory_data,
    input  logic [ROB_TAG_WIDTH-1:0] memory_rob_tag,
    input  logic                     kill_mem_req,
    output logic                     mem_if_busy,
    output logic                     dmem_req,
    output logic                     dmem_we,
    output logic [XLEN-1:0]          dmem_addr,
    output logic [XLEN-1:0]          dmem_wdata,
    output logic [XLEN/8-1:0]        dmem_be,
    input  logic                     dmem_ready,
    input  logic                     dmem_rvalid,
    input  logic [XLEN-1:0]          dmem_rdata,
    output logic                     load_succeeded,
    output logic [ROB_TAG_WIDTH-1:0] load_succeeded_rob_tag,
    output logic                     store_succeeded,
    output logic [ROB_TAG_WIDTH-1:0] store_succeeded_rob_tag,
    output logic                     cdb_request,
    input  logic                     cdb_grant,
    output logic [XLEN-1:0]          cdb_data,
    output logic [ROB_TAG_WIDTH-1:0] cdb_tag,
    output logic                     misaligned_exception,
    output logic [ROB_TAG_WIDTH-1:0] exception_rob_tag
);

    localparam int unsigned BE_W = XLEN / 8;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        REQ       = 3'd1,
        WAIT_RESP = 3'd2,
        DRAIN     = 3'd3,
        BROADCAST = 3'd4
    } state_e;

    state_e                   state_q, state_d;
    logic                     type_q, type_d;
    logic [2:0]               width_q, width_d;
    logic [XLEN-1:0]          addr_q, addr_d;
    logic [XLEN-1:0]          data_q, data_d;
    logic [ROB_TAG_WIDTH-1:0] tag_q, tag_d;
    logic [XLEN-1:0]          res_q, res_d;
    logic                     exc_q, exc_d;
    logic [ROB_TAG_WIDTH-1:0] exc_tag_q, exc_tag_d;
    logic                     st_ok_q, st_ok_d;
    logic [ROB_TAG_WIDTH-1:0] st_tag_q, st_tag_d;

    logic                     misaligned_c;
    logic [4:0]               lane_shift_c;
    logic [XLEN-1:0]          shifted_c;
    logic [XLEN-1:0]          load_ext_c;
    logic [BE_W-1:0]          store_be_c;
    logic                     load_kill_c;

    // Halfwords need even addresses, words need 4-byte alignment
    always_comb begin
        misaligned_c = 1'b0;
        case (memory_op_width[1:0])
            2'b01:   misaligned_c = memory_address[0];
            2'b10:   misaligned_c = (memory_address[1:0] != 2'b00);
            default: misaligned_c = 1'b0;
        endcase
    end

    assign lane_shift_c = {addr_q[1:0], 3'b000};
    assign shifted_c    = dmem_rdata >> lane_shift_c;
    assign load_kill_c  = kill_mem_req && !type_q;

    always_comb begin
        case (width_q)
            3'b000:  load_ext_c = {{(XLEN-8){shifted_c[7]}}, shifted_c[7:0]};
            3'b001:  load_ext_c = {{(XLEN-16){shifted_c[15]}}, shifted_c[15:0]};
            3'b100:  load_ext_c = {{(XLEN-8){1'b0}}, shifted_c[7:0]};
            3'b101:  load_ext_c = {{(XLEN-16){1'b0}}, shifted_c[15:0]};
            default: load_ext_c = shifted_c;
        endcase
    end

    always_comb begin
        case (width_q[1:0])
            2'b00:   store_be_c = BE_W'(4'b0001) << addr_q[1:0];
            2'b01:   store_be_c = BE_W'(4'b0011) << addr_q[1:0];
            default: store_be_c = BE_W'(4'b1111) << addr_q[1:0];
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            type_q    <= 1'b0;
            width_q   <= 3'b000;
            addr_q    <= '0;
            data_q    <= '0;
            tag_q     <= '0;
            res_q     <= '0;
            exc_q     <= 1'b0;
            exc_tag_q <= '0;
            st_ok_q   <= 1'b0;
            st_tag_q  <= '0;
        end else begin
            state_q   <= state_d;
            type_q    <= type_d;
            width_q   <= width_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            tag_q     <= tag_d;
            res_q     <= res_d;
            exc_q     <= exc_d;
            exc_tag_q <= exc_tag_d;
            st_ok_q   <= st_ok_d;
            st_tag_q  <= st_tag_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        type_d    = type_q;
        width_d   = width_q;
        addr_d    = addr_q;
        data_d    = data_q;
        tag_d     = tag_q;
        res_d     = res_q;
        exc_d     = 1'b0;
        exc_tag_d = '0;
        st_ok_d   = 1'b0;
        st_tag_d  = '0;
        case (state_q)
            IDLE: begin
                if (fire_memory_op) begin
                    type_d  = memory_op_type;
                    width_d = memory_op_width;
                    addr_d  = memory_address;
                    data_d  = memory_data;
                    tag_d   = memory_rob_tag;
                    if (misaligned_c) begin
                        exc_d     = 1'b1;
                        exc_tag_d = memory_rob_tag;
                    end else begin
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                // A killed load already accepted by memory must still sink its response
                if (load_kill_c) begin
                    state_d = dmem_ready ? DRAIN : IDLE;
                end else if (dmem_ready) begin
                    if (type_q) begin
                        st_ok_d  = 1'b1;
                        st_tag_d = tag_q;
                        state_d  = IDLE;
                    end else begin
                        state_d = WAIT_RESP;
                    end
                end
            end
            WAIT_RESP: begin
                if (load_kill_c) begin
                    state_d = dmem_rvalid ? IDLE : DRAIN;
                end else if (dmem_rvalid) begin
                    res_d   = load_ext_c;
                    state_d = BROADCAST;
                end
            end
            DRAIN: begin
                if (dmem_rvalid) state_d = IDLE;
            end
            BROADCAST: begin
                if (load_kill_c || cdb_grant) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign mem_if_busy             = (state_q != IDLE);
    assign dmem_req                = (state_q == REQ);
    assign dmem_we                 = dmem_req && type_q;
    assign dmem_addr               = dmem_req ? {addr_q[XLEN-1:2], 2'b00} : '0;
    assign dmem_wdata              = dmem_we ? (data_q << lane_shift_c) : '0;
    assign dmem_be                 = dmem_req ? (type_q ? store_be_c : '1) : '0;
    assign cdb_request             = (state_q == BROADCAST);
    assign cdb_data                = cdb_request ? res_q : '0;
    assign cdb_tag                 = cdb_request ? tag_q : '0;
    // Kill beats a same-cycle grant
    assign load_succeeded          = cdb_request && cdb_grant && !load_kill_c;
    assign load_succeeded_rob_tag  = load_succeeded ? tag_q : '0;
    assign store_succeeded         = st_ok_q;
    assign store_succeeded_rob_tag = st_tag_q;
    assign misaligned_exception    = exc_q;
    assign exception_rob_tag       = exc_tag_q;

endmodule
